// File: rtl/fft1024_pkg.sv
// Shared constants for the 1024-point FFT datapath: input word width, butterfly
// output width, and the radix-4 block geometry. Used by the 4:1 input
// deserializer, this radix-4 butterfly and the later FFT stages.
package fft1024_pkg;

  // Signed two's-complement width of each real/imag input word.
  localparam int unsigned WORDLENGTH = 16;
  // A radix-4 butterfly adds four words, so it grows by two bits.
  localparam int unsigned OUTLENGTH  = WORDLENGTH + 2;

  // Complex words per radix-4 block; this is also the minimum accept spacing.
  localparam int unsigned BlockLen   = 4;
  // Width of the down-counter that enforces the accept spacing (counts BlockLen-1..0).
  localparam int unsigned SpaceCntW  = 2;

endpackage

// File: rtl/r4_bfly_p4s1_if.sv
// Block-level bus of the radix-4 butterfly: four parallel complex input words
// with a block strobe, and one serial complex output word with bin index,
// valid and a sticky overrun flag.
//   master : producer/consumer side (drives in_valid and data_in*)
//   slave  : butterfly side (drives data_out*, out_valid, out_index, overrun)
interface r4_bfly_p4s1_if #(
  parameter int unsigned WORDLENGTH = fft1024_pkg::WORDLENGTH
);
  localparam int unsigned OUTLENGTH = WORDLENGTH + 2;

  logic                        in_valid;
  logic signed [WORDLENGTH-1:0] data_in0_re, data_in1_re, data_in2_re, data_in3_re;
  logic signed [WORDLENGTH-1:0] data_in0_im, data_in1_im, data_in2_im, data_in3_im;
  logic signed [OUTLENGTH-1:0]  data_out_re, data_out_im;
  logic                        out_valid;
  logic [1:0]                  out_index;
  logic                        overrun;

  modport master (
    output in_valid,
    output data_in0_re, data_in1_re, data_in2_re, data_in3_re,
    output data_in0_im, data_in1_im, data_in2_im, data_in3_im,
    input  data_out_re, data_out_im, out_valid, out_index, overrun
  );

  modport slave (
    input  in_valid,
    input  data_in0_re, data_in1_re, data_in2_re, data_in3_re,
    input  data_in0_im, data_in1_im, data_in2_im, data_in3_im,
    output data_out_re, data_out_im, out_valid, out_index, overrun
  );

endinterface

// File: rtl/p4s1_1.sv
// 4:1 parallel-to-serial converter for complex words. A load captures four
// words; word 0 appears on the next enabled cycle and words 1..3 follow on the
// three enabled cycles after that, with index_o = 0..3 and valid_o high.
// After the last word the data and index hold their values with valid_o low.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   enable_i         : global clock-enable; low holds every register
//   load_i           : capture x_re_i/x_im_i (wins over an ongoing shift)
//   x_re_i, x_im_i   : four parallel complex words
//   data_re_o/_im_o  : serial complex word
//   valid_o, index_o : word qualifier and its position 0..3
module p4s1_1
  import fft1024_pkg::*;
#(
  parameter int unsigned OUTLENGTH = fft1024_pkg::OUTLENGTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        load_i,
  input  logic signed [OUTLENGTH-1:0] x_re_i [BlockLen],
  input  logic signed [OUTLENGTH-1:0] x_im_i [BlockLen],
  output logic signed [OUTLENGTH-1:0] data_re_o,
  output logic signed [OUTLENGTH-1:0] data_im_o,
  output logic                        valid_o,
  output logic [1:0]                  index_o
);

  logic signed [OUTLENGTH-1:0] data_re_q, data_re_d, data_im_q, data_im_d;
  // Words still waiting to be shifted out, next one at element 0.
  logic signed [OUTLENGTH-1:0] hold_re_q [BlockLen-1];
  logic signed [OUTLENGTH-1:0] hold_re_d [BlockLen-1];
  logic signed [OUTLENGTH-1:0] hold_im_q [BlockLen-1];
  logic signed [OUTLENGTH-1:0] hold_im_d [BlockLen-1];
  logic [1:0]                  index_q, index_d;
  logic                        valid_q, valid_d;

  always_comb begin
    data_re_d = data_re_q;
    data_im_d = data_im_q;
    hold_re_d = hold_re_q;
    hold_im_d = hold_im_q;
    index_d   = index_q;
    valid_d   = valid_q;
    if (load_i) begin
      data_re_d = x_re_i[0];
      data_im_d = x_im_i[0];
      for (int i = 0; i < BlockLen - 1; i++) begin
        hold_re_d[i] = x_re_i[i+1];
        hold_im_d[i] = x_im_i[i+1];
      end
      index_d = 2'd0;
      valid_d = 1'b1;
    end else if (valid_q) begin
      if (index_q == 2'd3) begin
        // Last word already shown: drop valid, keep data parked on it.
        valid_d = 1'b0;
      end else begin
        data_re_d = hold_re_q[0];
        data_im_d = hold_im_q[0];
        for (int i = 0; i < BlockLen - 2; i++) begin
          hold_re_d[i] = hold_re_q[i+1];
          hold_im_d[i] = hold_im_q[i+1];
        end
        index_d = index_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_re_q <= '0;
      data_im_q <= '0;
      hold_re_q <= '{default: '0};
      hold_im_q <= '{default: '0};
      index_q   <= 2'd0;
      valid_q   <= 1'b0;
    end else if (enable_i) begin
      data_re_q <= data_re_d;
      data_im_q <= data_im_d;
      hold_re_q <= hold_re_d;
      hold_im_q <= hold_im_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
    end
  end

  assign data_re_o = data_re_q;
  assign data_im_o = data_im_q;
  assign valid_o   = valid_q;
  assign index_o   = index_q;

endmodule

// File: rtl/r4_bfly_p4s1.sv
// Radix-4 DIT butterfly with serial output. Accepts four parallel complex words
// a,b,c,d as one block, computes X0..X3 exactly (two register stages) and emits
// them one per enabled cycle, three enabled cycles after acceptance.
// Blocks must be spaced at least 4 enabled cycles apart; an early block is
// dropped and latches the sticky overrun flag.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   enable : global clock-enable; low holds all state and ignores in_valid
//   bus    : block input / serial output bus (slave side)
module r4_bfly_p4s1
  import fft1024_pkg::*;
#(
  parameter int unsigned WORDLENGTH = fft1024_pkg::WORDLENGTH
) (
  input logic           clk,
  input logic           rst,
  input logic           enable,
  r4_bfly_p4s1_if.slave bus
);

  localparam int unsigned OUTLENGTH = WORDLENGTH + 2;
  localparam int unsigned SumW      = WORDLENGTH + 1;

  // Enabled cycles left before another block may be accepted; 0 = ready.
  logic [SpaceCntW-1:0] space_q, space_d;
  logic                 accept, early;
  logic                 overrun_q;

  // Stage 1: a+c, a-c, b+d, b-d.
  logic                   v1_q;
  logic signed [SumW-1:0] apc_re_q, apc_im_q, amc_re_q, amc_im_q;
  logic signed [SumW-1:0] bpd_re_q, bpd_im_q, bmd_re_q, bmd_im_q;

  // Stage 2: X0..X3.
  logic                        v2_q;
  logic signed [OUTLENGTH-1:0] x_re_d [BlockLen];
  logic signed [OUTLENGTH-1:0] x_im_d [BlockLen];
  logic signed [OUTLENGTH-1:0] x_re_q [BlockLen];
  logic signed [OUTLENGTH-1:0] x_im_q [BlockLen];

  assign accept = enable & bus.in_valid & (space_q == '0);
  assign early  = enable & bus.in_valid & (space_q != '0);

  always_comb begin
    space_d = space_q;
    if (accept) begin
      space_d = SpaceCntW'(BlockLen - 1);
    end else if (space_q != '0) begin
      space_d = space_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      space_q   <= '0;
      overrun_q <= 1'b0;
    end else if (enable) begin
      space_q <= space_d;
      if (early) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q     <= 1'b0;
      apc_re_q <= '0;
      apc_im_q <= '0;
      amc_re_q <= '0;
      amc_im_q <= '0;
      bpd_re_q <= '0;
      bpd_im_q <= '0;
      bmd_re_q <= '0;
      bmd_im_q <= '0;
    end else if (enable) begin
      v1_q <= accept;
      // Dropped blocks never reach the sum registers.
      if (accept) begin
        apc_re_q <= SumW'(bus.data_in0_re) + SumW'(bus.data_in2_re);
        apc_im_q <= SumW'(bus.data_in0_im) + SumW'(bus.data_in2_im);
        amc_re_q <= SumW'(bus.data_in0_re) - SumW'(bus.data_in2_re);
        amc_im_q <= SumW'(bus.data_in0_im) - SumW'(bus.data_in2_im);
        bpd_re_q <= SumW'(bus.data_in1_re) + SumW'(bus.data_in3_re);
        bpd_im_q <= SumW'(bus.data_in1_im) + SumW'(bus.data_in3_im);
        bmd_re_q <= SumW'(bus.data_in1_re) - SumW'(bus.data_in3_re);
        bmd_im_q <= SumW'(bus.data_in1_im) - SumW'(bus.data_in3_im);
      end
    end
  end

  // X1 = (a-c) - j(b-d), X3 = (a-c) + j(b-d).
  always_comb begin
    x_re_d[0] = OUTLENGTH'(apc_re_q) + OUTLENGTH'(bpd_re_q);
    x_im_d[0] = OUTLENGTH'(apc_im_q) + OUTLENGTH'(bpd_im_q);
    x_re_d[1] = OUTLENGTH'(amc_re_q) + OUTLENGTH'(bmd_im_q);
    x_im_d[1] = OUTLENGTH'(amc_im_q) - OUTLENGTH'(bmd_re_q);
    x_re_d[2] = OUTLENGTH'(apc_re_q) - OUTLENGTH'(bpd_re_q);
    x_im_d[2] = OUTLENGTH'(apc_im_q) - OUTLENGTH'(bpd_im_q);
    x_re_d[3] = OUTLENGTH'(amc_re_q) - OUTLENGTH'(bmd_im_q);
    x_im_d[3] = OUTLENGTH'(amc_im_q) + OUTLENGTH'(bmd_re_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q   <= 1'b0;
      x_re_q <= '{default: '0};
      x_im_q <= '{default: '0};
    end else if (enable) begin
      v2_q <= v1_q;
      if (v1_q) begin
        x_re_q <= x_re_d;
        x_im_q <= x_im_d;
      end
    end
  end

  p4s1_1 #(
    .OUTLENGTH (OUTLENGTH)
  ) u_p4s1_1 (
    .clk_i     (clk),
    .rst_ni    (rst),
    .enable_i  (enable),
    .load_i    (v2_q),
    .x_re_i    (x_re_q),
    .x_im_i    (x_im_q),
    .data_re_o (bus.data_out_re),
    .data_im_o (bus.data_out_im),
    .valid_o   (bus.out_valid),
    .index_o   (bus.out_index)
  );

  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_r4_bfly_p4s1.sv
// Randomized scoreboard bench for r4_bfly_p4s1. The driver computes each
// accepted block's 4-point DFT directly (sum of x[n]*(-j)^(nk)) and queues the
// four expected words stamped with the enabled-cycle count at which they must
// appear; a negedge monitor compares whatever the DUT presents.
module tb_r4_bfly_p4s1;

  localparam int unsigned WL = 16;

  typedef struct {
    int re;
    int im;
    int idx;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;

  r4_bfly_p4s1_if #(.WORDLENGTH(WL)) bus ();

  r4_bfly_p4s1 #(
    .WORDLENGTH (WL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   ecyc = 0;       // enabled clock edges seen while out of reset
  int   nchk = 0;
  int   nerr = 0;
  bit   have_last = 1'b0;
  int   last_acc = 0;
  bit   ovr_set = 1'b0;
  int   ovr_at = 0;
  int   run_cur = 0;
  int   run_max = 0;
  int   xr[4];
  int   xi[4];

  always @(posedge clk) if (rst && enable) ecyc <= ecyc + 1;

  function automatic void chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // X_k = sum_n x_n * (-j)^(n*k)
  function automatic void push_block(int stamp);
    int sr;
    int si;
    for (int k = 0; k < 4; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0:       begin sr += xr[n]; si += xi[n]; end
          1:       begin sr += xi[n]; si -= xr[n]; end
          2:       begin sr -= xr[n]; si -= xi[n]; end
          default: begin sr -= xi[n]; si += xr[n]; end
        endcase
      end
      sb.push_back('{re: sr, im: si, idx: k, cyc: stamp + 3 + k});
    end
  endfunction

  task automatic load(input int r0, i0, r1, i1, r2, i2, r3, i3);
    xr[0] = r0; xi[0] = i0; xr[1] = r1; xi[1] = i1;
    xr[2] = r2; xi[2] = i2; xr[3] = r3; xi[3] = i3;
  endtask

  task automatic rnd_blk();
    logic signed [WL-1:0] r;
    for (int n = 0; n < 4; n++) begin
      r = WL'($urandom);
      xr[n] = int'(r);
      r = WL'($urandom);
      xi[n] = int'(r);
    end
  endtask

  task automatic step(input bit en, input bit iv);
    @(posedge clk);
    #1;
    enable       = en;
    bus.in_valid = iv;
    bus.data_in0_re = WL'(xr[0]); bus.data_in0_im = WL'(xi[0]);
    bus.data_in1_re = WL'(xr[1]); bus.data_in1_im = WL'(xi[1]);
    bus.data_in2_re = WL'(xr[2]); bus.data_in2_im = WL'(xi[2]);
    bus.data_in3_re = WL'(xr[3]); bus.data_in3_im = WL'(xi[3]);
    if (en && iv) begin
      if (!have_last || (ecyc - last_acc >= 4)) begin
        push_block(ecyc);
        have_last = 1'b1;
        last_acc  = ecyc;
      end else if (!ovr_set) begin
        ovr_set = 1'b1;
        ovr_at  = ecyc + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " data_out_re"}, int'(bus.data_out_re), 0);
    chk({tag, " data_out_im"}, int'(bus.data_out_im), 0);
    chk({tag, " out_index"}, int'(bus.out_index), 0);
    chk({tag, " overrun"}, int'(bus.overrun), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("overrun", int'(bus.overrun), int'(ovr_set && (ecyc >= ovr_at)));
      if (bus.out_valid) begin
        if (enable) run_cur++;
        if (run_cur > run_max) run_max = run_cur;
        if (sb.size() == 0) begin
          chk("residual out_valid", 1, 0);
        end else begin
          chk("out_re", int'(bus.data_out_re), sb[0].re);
          chk("out_im", int'(bus.data_out_im), sb[0].im);
          chk("out_index", int'(bus.out_index), sb[0].idx);
          chk("out_cycle", ecyc, sb[0].cyc);
          if (enable) void'(sb.pop_front());
        end
      end else begin
        run_cur = 0;
        chk("word missing", int'(sb.size() != 0 && sb[0].cyc <= ecyc), 0);
        if (sb.size() != 0 && sb[0].cyc <= ecyc) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    bus.data_in0_re = '0; bus.data_in0_im = '0; bus.data_in1_re = '0; bus.data_in1_im = '0;
    bus.data_in2_re = '0; bus.data_in2_im = '0; bus.data_in3_re = '0; bus.data_in3_im = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    // Directed blocks: impulse, DC, j-rotation, full-scale negative.
    load(100, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1);
    idle(8);
    load(1, 0, 1, 0, 1, 0, 1, 0);
    step(1'b1, 1'b1);
    idle(8);
    load(0, 0, 0, 1, 0, 0, 0, 0);
    step(1'b1, 1'b1);
    idle(8);
    load(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    step(1'b1, 1'b1);
    idle(8);
    chk("overrun idle", int'(bus.overrun), 0);

    // Back-to-back streaming, then an early block two cycles after an accept.
    run_max = 0;
    for (int b = 0; b < 3; b++) begin
      rnd_blk();
      step(1'b1, 1'b1);
      if (b < 2) idle(3);
    end
    idle(1);
    rnd_blk();
    step(1'b1, 1'b1);
    idle(10);
    chk("stream out_valid run", run_max, 12);
    chk("overrun sticky", int'(bus.overrun), 1);

    // Freeze mid-output with in_valid held high; it must be ignored.
    rnd_blk();
    step(1'b1, 1'b1);
    idle(4);
    repeat (5) step(1'b0, 1'b1);
    idle(8);

    // Random spacing, random enable.
    for (int i = 0; i < 80; i++) begin
      rnd_blk();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0);
    end
    idle(10);

    // Asynchronous reset in the middle of a block's output.
    rnd_blk();
    step(1'b1, 1'b1);
    idle(4);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_zero("mid-block reset");
    sb.delete();
    have_last = 1'b0;
    ovr_set   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(10);

    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
